// File: rtl/fcvt_int_s_pipe_if.sv
// Handshake bundle for fcvt_int_s_pipe.
//   in_*  : op channel (valid/ready, binary32 operand, rounding mode, signedness, tag)
//   out_* : result channel (valid/ready, integer result, NV/NX flags, tag)
// master = op issuer and result consumer; slave = the converter.
interface fcvt_int_s_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [2:0]       in_rm;
    logic             in_unsigned;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_y;
    logic             out_nv;
    logic             out_nx;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_rm, in_unsigned, in_tag, out_ready,
        input  in_ready, out_valid, out_y, out_nv, out_nx, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_rm, in_unsigned, in_tag, out_ready,
        output in_ready, out_valid, out_y, out_nv, out_nx, out_tag
    );
endinterface

// File: rtl/fcvt_int_s_pipe.sv
// Three-stage FP32 -> XLEN-bit integer converter (FCVT.W[U].S / FCVT.L[U].S).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous kill of every in-flight op; blocks same-cycle input
//   bus        : fcvt_int_s_pipe_if.slave (op channel in, result channel out)
// Build option: define FCVT_ROUND_EN for RNE/RTZ/RDN/RUP/RMM; otherwise all ops
// truncate (RTZ) and in_rm is ignored.
module fcvt_int_s_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    fcvt_int_s_pipe_if.slave bus
);
    localparam int unsigned SH_W = $clog2(XLEN + 2);
    localparam int unsigned SV_W = XLEN + 25;
    localparam int unsigned M_W  = XLEN + 2;
    // Biased exponents bounding the shifter window e in [-1, XLEN]
    localparam logic [7:0]      E_LO     = 8'd126;
    localparam logic [7:0]      E_HI     = 8'(127 + XLEN);
    localparam logic [M_W-1:0]  LIM_SPOS = {3'b000, {(XLEN-1){1'b1}}};
    localparam logic [M_W-1:0]  LIM_SNEG = {3'b001, {(XLEN-1){1'b0}}};
    localparam logic [M_W-1:0]  LIM_U    = {2'b00, {XLEN{1'b1}}};
    localparam logic [XLEN-1:0] Y_SMAX   = {1'b0, {(XLEN-1){1'b1}}};
    localparam logic [XLEN-1:0] Y_SMIN   = {1'b1, {(XLEN-1){1'b0}}};

    // Pipeline occupancy and handshake
    logic v1, v2, v3;
    logic free1, free2, free3, accept;

    assign free3         = !v3 || bus.out_ready;
    assign free2         = !v2 || free3;
    assign free1         = !v1 || free2;
    assign bus.in_ready  = free1 && !flush;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = v3;

    // S1: unpack and classify
    logic [7:0]  a_exp;
    logic [22:0] a_frac;
    logic        a_nan, a_ovf, a_shift, a_tiny;

    assign a_exp   = bus.in_a[30:23];
    assign a_frac  = bus.in_a[22:0];
    assign a_nan   = (a_exp == 8'hFF) && (a_frac != 23'd0);
    assign a_ovf   = (a_exp > E_HI) && !a_nan;   // includes +-inf
    assign a_shift = (a_exp >= E_LO) && (a_exp <= E_HI);
    // Nonzero values below 0.5 only contribute to sticky
    assign a_tiny  = ((a_exp != 8'd0) && (a_exp < E_LO)) ||
                     ((a_exp == 8'd0) && (a_frac != 23'd0));

    logic             s1_sign, s1_nan, s1_ovf, s1_shift, s1_tiny, s1_uns;
    logic [23:0]      s1_mant;
    logic [SH_W-1:0]  s1_sh;
    logic [TAG_W-1:0] s1_tag;
`ifdef FCVT_ROUND_EN
    logic [2:0]       s1_rm;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            s1_sign  <= 1'b0;
            s1_nan   <= 1'b0;
            s1_ovf   <= 1'b0;
            s1_shift <= 1'b0;
            s1_tiny  <= 1'b0;
            s1_uns   <= 1'b0;
            s1_mant  <= '0;
            s1_sh    <= '0;
            s1_tag   <= '0;
`ifdef FCVT_ROUND_EN
            s1_rm    <= '0;
`endif
        end else begin
            if (flush)      v1 <= 1'b0;
            else if (free1) v1 <= accept;
            if (accept) begin
                s1_sign  <= bus.in_a[31];
                s1_nan   <= a_nan;
                s1_ovf   <= a_ovf;
                s1_shift <= a_shift;
                s1_tiny  <= a_tiny;
                s1_uns   <= bus.in_unsigned;
                s1_mant  <= {1'b1, a_frac};
                s1_sh    <= SH_W'(a_exp - E_LO);
                s1_tag   <= bus.in_tag;
`ifdef FCVT_ROUND_EN
                s1_rm    <= bus.in_rm;
`endif
            end
        end
    end

    // S2: align to integer + guard + sticky (binary point sits at bit 24 of shifted)
    logic [SV_W-1:0] shifted;
    logic [XLEN:0]   ipart;
    logic            guard, sticky, inc;
    logic [M_W-1:0]  mag_c;

    always_comb begin
        shifted = SV_W'(s1_mant) << s1_sh;
        ipart   = '0;
        guard   = 1'b0;
        sticky  = s1_tiny;
        if (s1_shift) begin
            ipart  = shifted[SV_W-1:24];
            guard  = shifted[23];
            sticky = |shifted[22:0];
        end
    end

`ifdef FCVT_ROUND_EN
    // Round-up decision on the magnitude; reserved encodings truncate
    always_comb begin
        inc = 1'b0;
        case (s1_rm)
            3'b000:  inc = guard && (sticky || ipart[0]);
            3'b010:  inc = s1_sign && (guard || sticky);
            3'b011:  inc = !s1_sign && (guard || sticky);
            3'b100:  inc = guard;
            default: inc = 1'b0;
        endcase
    end
`else
    assign inc = 1'b0;
`endif

    assign mag_c = M_W'(ipart) + M_W'(inc);

    logic             s2_sign, s2_nan, s2_ovf, s2_uns, s2_inexact;
    logic [M_W-1:0]   s2_mag;
    logic [TAG_W-1:0] s2_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2         <= 1'b0;
            s2_sign    <= 1'b0;
            s2_nan     <= 1'b0;
            s2_ovf     <= 1'b0;
            s2_uns     <= 1'b0;
            s2_inexact <= 1'b0;
            s2_mag     <= '0;
            s2_tag     <= '0;
        end else begin
            if (flush)      v2 <= 1'b0;
            else if (free2) v2 <= v1;
            if (free2 && v1) begin
                s2_sign    <= s1_sign;
                s2_nan     <= s1_nan;
                s2_ovf     <= s1_ovf;
                s2_uns     <= s1_uns;
                s2_inexact <= guard || sticky;
                s2_mag     <= mag_c;
                s2_tag     <= s1_tag;
            end
        end
    end

    // S3: range check, saturation, sign apply, flags
    logic [XLEN-1:0] mag_lo, y_c;
    logic            nv_c, nx_c;

    assign mag_lo = s2_mag[XLEN-1:0];

    always_comb begin
        y_c  = '0;
        nv_c = 1'b0;
        if (s2_nan) begin
            y_c  = s2_uns ? '1 : Y_SMAX;
            nv_c = 1'b1;
        end else if (s2_uns) begin
            if (s2_sign) begin
                // Negative to unsigned: only a value rounding to zero is legal
                nv_c = s2_ovf || (s2_mag != '0);
            end else if (s2_ovf || (s2_mag > LIM_U)) begin
                y_c  = '1;
                nv_c = 1'b1;
            end else begin
                y_c = mag_lo;
            end
        end else if (s2_sign) begin
            if (s2_ovf || (s2_mag > LIM_SNEG)) begin
                y_c  = Y_SMIN;
                nv_c = 1'b1;
            end else begin
                y_c = -mag_lo;
            end
        end else if (s2_ovf || (s2_mag > LIM_SPOS)) begin
            y_c  = Y_SMAX;
            nv_c = 1'b1;
        end else begin
            y_c = mag_lo;
        end
        nx_c = s2_inexact && !nv_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3          <= 1'b0;
            bus.out_y   <= '0;
            bus.out_nv  <= 1'b0;
            bus.out_nx  <= 1'b0;
            bus.out_tag <= '0;
        end else begin
            if (flush)      v3 <= 1'b0;
            else if (free3) v3 <= v2;
            if (free3 && v2) begin
                bus.out_y   <= y_c;
                bus.out_nv  <= nv_c;
                bus.out_nx  <= nx_c;
                bus.out_tag <= s2_tag;
            end
        end
    end
endmodule

// File: tb/tb_fcvt_int_s_pipe.sv
// Scoreboard bench for fcvt_int_s_pipe: one 32-bit and one 64-bit instance.
// Stimulus pushes expected results; per-instance monitors pop and compare on
// every accepted output and check hold stability under backpressure.
module tb_fcvt_int_s_pipe;
    localparam int unsigned TAG_W = 5;
    localparam logic [2:0] RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010,
                           RUP = 3'b011, RMM = 3'b100;

    typedef struct packed {
        logic [63:0]      y;
        logic             nv;
        logic             nx;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush32, flush64;
    logic hold32 = 1'b0;
    logic hold64 = 1'b0;
    logic saw_block32 = 1'b0;
    logic [TAG_W-1:0] tag32 = '0;
    logic [TAG_W-1:0] tag64 = '0;
    int checks = 0;
    int failures = 0;
    exp_t q32[$];
    exp_t q64[$];

    always #5 clk = ~clk;

    fcvt_int_s_pipe_if #(.XLEN(32), .TAG_W(TAG_W)) b32 ();
    fcvt_int_s_pipe_if #(.XLEN(64), .TAG_W(TAG_W)) b64 ();

    fcvt_int_s_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush32), .bus(b32)
    );
    fcvt_int_s_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush64), .bus(b64)
    );

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // 32-bit monitor: drives out_ready, checks hold stability, pops scoreboard
    exp_t e32;
    logic held32 = 1'b0;
    logic [31:0] hy32;
    logic hnv32, hnx32;
    logic [TAG_W-1:0] htag32;

    always @(negedge clk) begin
        b32.out_ready = !hold32;
        if (held32) begin
            checks++;
            if ({b32.out_valid, b32.out_y, b32.out_nv, b32.out_nx, b32.out_tag} !==
                {1'b1, hy32, hnv32, hnx32, htag32}) begin
                failures++;
                $display("FAIL hold32 got v=%b y=%h tag=%0d exp y=%h tag=%0d",
                         b32.out_valid, b32.out_y, b32.out_tag, hy32, htag32);
            end
        end
        held32 = b32.out_valid && !b32.out_ready;
        hy32   = b32.out_y;
        hnv32  = b32.out_nv;
        hnx32  = b32.out_nx;
        htag32 = b32.out_tag;
        if (b32.out_valid && b32.out_ready) begin
            checks++;
            if (q32.size() == 0) begin
                failures++;
                $display("FAIL out32 unexpected result y=%h tag=%0d", b32.out_y, b32.out_tag);
            end else begin
                e32 = q32.pop_front();
                if ({b32.out_y, b32.out_nv, b32.out_nx, b32.out_tag} !==
                    {e32.y[31:0], e32.nv, e32.nx, e32.tag}) begin
                    failures++;
                    $display("FAIL out32 got y=%h nv=%b nx=%b tag=%0d exp y=%h nv=%b nx=%b tag=%0d",
                             b32.out_y, b32.out_nv, b32.out_nx, b32.out_tag,
                             e32.y[31:0], e32.nv, e32.nx, e32.tag);
                end
            end
        end
    end

    // 64-bit monitor
    exp_t e64;

    always @(negedge clk) begin
        b64.out_ready = !hold64;
        if (b64.out_valid && b64.out_ready) begin
            checks++;
            if (q64.size() == 0) begin
                failures++;
                $display("FAIL out64 unexpected result y=%h tag=%0d", b64.out_y, b64.out_tag);
            end else begin
                e64 = q64.pop_front();
                if ({b64.out_y, b64.out_nv, b64.out_nx, b64.out_tag} !==
                    {e64.y, e64.nv, e64.nx, e64.tag}) begin
                    failures++;
                    $display("FAIL out64 got y=%h nv=%b nx=%b tag=%0d exp y=%h nv=%b nx=%b tag=%0d",
                             b64.out_y, b64.out_nv, b64.out_nx, b64.out_tag,
                             e64.y, e64.nv, e64.nx, e64.tag);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge
    task automatic send(input bit w64, input logic [31:0] a, input logic [2:0] rm,
                        input logic uns, input logic [63:0] ey, input logic env,
                        input logic enx, input bit push);
        logic rdy;
        int n;
        exp_t e;
        if (w64) begin
            b64.in_valid = 1'b1; b64.in_a = a; b64.in_rm = rm;
            b64.in_unsigned = uns; b64.in_tag = tag64;
        end else begin
            b32.in_valid = 1'b1; b32.in_a = a; b32.in_rm = rm;
            b32.in_unsigned = uns; b32.in_tag = tag32;
        end
        @(negedge clk); #1;
        n = 0;
        rdy = w64 ? b64.in_ready : b32.in_ready;
        while (!rdy && n < 50) begin
            @(negedge clk); #1;
            n++;
            rdy = w64 ? b64.in_ready : b32.in_ready;
        end
        if (!rdy) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout a=%h", a);
            b32.in_valid = 1'b0;
            b64.in_valid = 1'b0;
            return;
        end
        if (n > 0 && !w64) saw_block32 = 1'b1;
        @(posedge clk); #1;
        e.y = ey; e.nv = env; e.nx = enx;
        e.tag = w64 ? tag64 : tag32;
        if (push) begin
            if (w64) q64.push_back(e);
            else     q32.push_back(e);
        end
        if (w64) tag64 = tag64 + 1'b1;
        else     tag32 = tag32 + 1'b1;
    endtask

    // Expected value depends on whether directed rounding is built in
    task automatic sv(input bit w64, input logic [31:0] a, input logic [2:0] rm,
                      input logic uns, input logic [63:0] y_rnd, input logic [63:0] y_rtz,
                      input logic env, input logic enx);
`ifdef FCVT_ROUND_EN
        send(w64, a, rm, uns, y_rnd, env, enx, 1'b1);
`else
        send(w64, a, rm, uns, y_rtz, env, enx, 1'b1);
`endif
    endtask

    task automatic idle();
        b32.in_valid = 1'b0;
        b64.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending", 128'(q32.size() + q64.size()), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush32 = 1'b0; flush64 = 1'b0;
        b32.in_valid = 1'b0; b32.in_a = '0; b32.in_rm = '0; b32.in_unsigned = 1'b0; b32.in_tag = '0;
        b64.in_valid = 1'b0; b64.in_a = '0; b64.in_rm = '0; b64.in_unsigned = 1'b0; b64.in_tag = '0;
        @(negedge clk); #1;
        chk("rst32_ctl", {b32.out_valid, b32.out_nv, b32.out_nx, b32.in_ready}, 4'b0001);
        chk("rst32_data", {b32.out_y, b32.out_tag}, '0);
        chk("rst64_ctl", {b64.out_valid, b64.out_nv, b64.out_nx, b64.in_ready}, 4'b0001);
        chk("rst64_data", {b64.out_y, b64.out_tag}, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Rounding modes, ties and sign (XLEN=32)
        sv(0, 32'h3FC00000, RNE, 0, 64'd2, 64'd1, 0, 1);
        sv(0, 32'h3FC00000, RTZ, 0, 64'd1, 64'd1, 0, 1);
        sv(0, 32'h40200000, RNE, 0, 64'd2, 64'd2, 0, 1);
        sv(0, 32'hC0200000, RNE, 0, 64'hFFFFFFFE, 64'hFFFFFFFE, 0, 1);
        sv(0, 32'hC0200000, RMM, 0, 64'hFFFFFFFD, 64'hFFFFFFFE, 0, 1);
        sv(0, 32'hC0200000, RDN, 0, 64'hFFFFFFFD, 64'hFFFFFFFE, 0, 1);
        sv(0, 32'hC0200000, RUP, 0, 64'hFFFFFFFE, 64'hFFFFFFFE, 0, 1);
        sv(0, 32'h3FC00000, 3'b101, 0, 64'd1, 64'd1, 0, 1);
        sv(0, 32'h3F000000, RMM, 0, 64'd1, 64'd0, 0, 1);
        // Range limits and specials
        sv(0, 32'h4F000000, RTZ, 0, 64'h7FFFFFFF, 64'h7FFFFFFF, 1, 0);
        sv(0, 32'h4F000000, RTZ, 1, 64'h80000000, 64'h80000000, 0, 0);
        sv(0, 32'hCF000000, RTZ, 0, 64'h80000000, 64'h80000000, 0, 0);
        sv(0, 32'hCF000001, RTZ, 0, 64'h80000000, 64'h80000000, 1, 0);
        sv(0, 32'h4EFFFFFF, RNE, 0, 64'h7FFFFF80, 64'h7FFFFF80, 0, 0);
        sv(0, 32'h4F7FFFFF, RTZ, 1, 64'hFFFFFF00, 64'hFFFFFF00, 0, 0);
        sv(0, 32'h4F800000, RTZ, 1, 64'hFFFFFFFF, 64'hFFFFFFFF, 1, 0);
        sv(0, 32'h7FC00000, RNE, 0, 64'h7FFFFFFF, 64'h7FFFFFFF, 1, 0);
        sv(0, 32'h7FC00000, RTZ, 1, 64'hFFFFFFFF, 64'hFFFFFFFF, 1, 0);
        sv(0, 32'h7F800000, RTZ, 0, 64'h7FFFFFFF, 64'h7FFFFFFF, 1, 0);
        sv(0, 32'hFF800000, RTZ, 1, 64'd0, 64'd0, 1, 0);
        sv(0, 32'hBF000000, RTZ, 1, 64'd0, 64'd0, 0, 1);
        sv(0, 32'hBF800000, RTZ, 1, 64'd0, 64'd0, 1, 0);
        // Tiny values, zero, subnormals
        sv(0, 32'h80000000, RNE, 0, 64'd0, 64'd0, 0, 0);
        sv(0, 32'h00000001, RTZ, 0, 64'd0, 64'd0, 0, 1);
        sv(0, 32'h80000001, RDN, 0, 64'hFFFFFFFF, 64'd0, 0, 1);
        sv(0, 32'h3E800000, RUP, 0, 64'd1, 64'd0, 0, 1);
        sv(0, 32'h3F7FFFFF, RNE, 0, 64'd1, 64'd0, 0, 1);
        idle();
        drain();

        // Ten back-to-back ops with a five-cycle output stall
        fork
            begin
                logic [31:0] ints [10];
                ints = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                         32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
                for (int k = 0; k < 10; k++)
                    send(0, ints[k], RTZ, 1'(k % 2), 64'(k + 1), 0, 0, 1);
                idle();
            end
            begin
                repeat (4) @(posedge clk);
                #1 hold32 = 1'b1;
                repeat (5) @(posedge clk);
                #1 hold32 = 1'b0;
            end
        join
        drain();
        chk("backpressure_seen", 128'(saw_block32), 128'd1);

        // XLEN=64 conversions
        sv(1, 32'h5F000000, RTZ, 0, 64'h7FFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF, 1, 0);
        sv(1, 32'h5F000000, RTZ, 1, 64'h8000000000000000, 64'h8000000000000000, 0, 0);
        sv(1, 32'hDF000000, RTZ, 0, 64'h8000000000000000, 64'h8000000000000000, 0, 0);
        sv(1, 32'h5F800000, RTZ, 1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1, 0);
        sv(1, 32'h60000000, RTZ, 0, 64'h7FFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF, 1, 0);
        sv(1, 32'h4F800000, RTZ, 0, 64'h0000000100000000, 64'h0000000100000000, 0, 0);
        sv(1, 32'hC0200000, RNE, 0, 64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 0, 1);
        sv(1, 32'h3FC00000, RNE, 0, 64'd2, 64'd1, 0, 1);
        idle();
        drain();

        // Flush with three ops in flight (output stalled so none escape first)
        hold64 = 1'b1;
        for (int k = 0; k < 3; k++)
            send(1, 32'h5F000000, RTZ, 0, 64'd0, 0, 0, 0);
        flush64 = 1'b1;
        @(negedge clk); #1;
        chk("flush_in_ready", 128'(b64.in_ready), 128'd0);
        @(posedge clk); #1;
        flush64 = 1'b0;
        idle();
        hold64 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            chk("flush_out_valid", 128'(b64.out_valid), 128'd0);
        end
        @(posedge clk); #1;

        // Asynchronous reset with ops in flight
        hold64 = 1'b1;
        for (int k = 0; k < 3; k++)
            send(1, 32'h5F000000, RTZ, 1, 64'd0, 0, 0, 0);
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ctl", {b64.out_valid, b64.out_nv, b64.out_nx, b64.in_ready}, 4'b0001);
        chk("rst_mid_data", {b64.out_y, b64.out_tag}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        hold64 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("rst_mid_out_valid", 128'(b64.out_valid), 128'd0);
        end
        @(posedge clk); #1;
        sv(1, 32'h4F800000, RTZ, 1, 64'h0000000100000000, 64'h0000000100000000, 0, 0);
        idle();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
